// File: rtl/bus_ram_if.sv
// rtl/bus_ram_if.sv - bus_ram request/response bundle (error_out present when BUS_RAM_ERR_EN is defined)
interface bus_ram_if;
    logic [63:0] address_in;
    logic        read_in;
    logic        write_in;
    logic [7:0]  write_mask_in;
    logic [63:0] write_value_in;
    logic [63:0] read_value_out;
    logic        ready_out;
`ifdef BUS_RAM_ERR_EN
    logic        error_out;
`endif

    // Arbiter side drives requests and samples the completion.
    modport master (
        output address_in, read_in, write_in, write_mask_in, write_value_in,
        input  read_value_out, ready_out
`ifdef BUS_RAM_ERR_EN
        , input error_out
`endif
    );

    // RAM side samples requests and drives the completion.
    modport slave (
        input  address_in, read_in, write_in, write_mask_in, write_value_in,
        output read_value_out, ready_out
`ifdef BUS_RAM_ERR_EN
        , output error_out
`endif
    );
endinterface

// File: rtl/bus_ram.sv
// rtl/bus_ram.sv - byte-maskable 64-bit bus RAM responder with fixed latency (optional BUS_RAM_ERR_EN range check)
module bus_ram #(
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          READ_LATENCY = 1,
    parameter logic [63:0] BASE_ADDR    = 64'h0
) (
    input  logic    clk,
    input  logic    reset_n,
    bus_ram_if.slave bus
);
    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN        = 64'(DEPTH_WORDS) << 3;
    localparam logic [3:0]  LAT_PRELOAD = 4'((READ_LATENCY > 1) ? (READ_LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [63:0]      mem [DEPTH_WORDS];
    state_t           state;
    state_t           state_next;
    logic [3:0]       counter;
    logic [63:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             req;
    logic             accept;
    logic             in_range;
    logic             do_write;
    logic [63:0]      ram_word;
    logic [63:0]      capture_word;
    logic [63:0]      rdata_q;
    logic             ready_q;
    logic [63:0]      read_value_q;
    logic             unused_bits;

    assign offset       = bus.address_in - BASE_ADDR;
    assign idx          = offset[IDX_W+2:3];
    assign unused_bits  = ^{offset[63:IDX_W+3], offset[2:0]};
    assign req          = bus.read_in | bus.write_in;
    assign accept       = (state == IDLE) && req;
    assign ram_word     = mem[idx];

`ifdef BUS_RAM_ERR_EN
    // Offsets below BASE_ADDR wrap to huge unsigned values, so one compare covers both ends.
    assign in_range     = (offset < SPAN);
`else
    assign in_range     = 1'b1;
`endif

    // Out-of-range accesses return zero and never touch the array.
    assign capture_word = in_range ? ram_word : 64'h0;
    assign do_write     = accept && bus.write_in && in_range;

    // State register; reset abandons any response in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: IDLE accepts, WAIT burns the latency, DONE presents for one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = (READ_LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (counter == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latency counter, captured word and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            counter      <= 4'd0;
            rdata_q      <= 64'h0;
            ready_q      <= 1'b0;
            read_value_q <= 64'h0;
        end else begin
            if (accept) begin
                counter <= LAT_PRELOAD;
                rdata_q <= capture_word;
            end else if ((state == WAIT) && (counter != 4'd0)) begin
                counter <= counter - 4'd1;
            end
            ready_q      <= (state_next == DONE);
            read_value_q <= (state_next == DONE) ? (accept ? capture_word : rdata_q) : 64'h0;
        end
    end

    // Masked write commits at the accept edge, so a later reset cannot undo it.
    always_ff @(posedge clk) begin
        if (reset_n && do_write) begin
            for (int b = 0; b < 8; b++) begin
                if (bus.write_mask_in[b]) begin
                    mem[idx][8*b +: 8] <= bus.write_value_in[8*b +: 8];
                end
            end
        end
    end

`ifdef BUS_RAM_ERR_EN
    logic err_hold;
    logic err_q;

    // Range error travels with the transaction and is shown only alongside ready.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_hold <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                err_hold <= !in_range;
            end
            err_q <= (state_next == DONE) && (accept ? !in_range : err_hold);
        end
    end

    assign bus.error_out = err_q;
`endif

    assign bus.ready_out      = ready_q;
    assign bus.read_value_out = read_value_q;
endmodule

// File: tb/tb_bus_ram.sv
// tb/tb_bus_ram.sv - scoreboard bench for bus_ram at latency 1 and latency 4
module tb_bus_ram;
`ifdef BUS_RAM_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    typedef struct {
        logic [63:0] data;
        int          cyc;
        bit          dc;
        bit          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst1_n = 1'b0;
    logic rst4_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q1[$];
    exp_t q4[$];
    logic err1;
    logic err4;

    bus_ram_if bus1 ();
    bus_ram_if bus4 ();

    bus_ram #(.DEPTH_WORDS(1024), .READ_LATENCY(1), .BASE_ADDR(64'h0)) dut1 (
        .clk(clk), .reset_n(rst1_n), .bus(bus1.slave)
    );
    bus_ram #(.DEPTH_WORDS(16), .READ_LATENCY(4), .BASE_ADDR(64'h1000)) dut4 (
        .clk(clk), .reset_n(rst4_n), .bus(bus4.slave)
    );

`ifdef BUS_RAM_ERR_EN
    assign err1 = bus1.error_out;
    assign err4 = bus4.error_out;
`else
    assign err1 = 1'b0;
    assign err4 = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic drive(input int sel, input logic [63:0] addr, input logic rd, input logic wr,
                         input logic [7:0] mask, input logic [63:0] val);
        if (sel == 1) begin
            bus1.address_in = addr; bus1.read_in = rd; bus1.write_in = wr;
            bus1.write_mask_in = mask; bus1.write_value_in = val;
        end else begin
            bus4.address_in = addr; bus4.read_in = rd; bus4.write_in = wr;
            bus4.write_mask_in = mask; bus4.write_value_in = val;
        end
    endtask

    task automatic issue(input int sel, input logic [63:0] addr, input logic rd, input logic wr,
                         input logic [7:0] mask, input logic [63:0] val,
                         input logic [63:0] expv, input bit dc, input bit experr);
        exp_t e;
        bit   seen;
        e.data = expv;
        e.cyc  = cyc + ((sel == 1) ? 1 : 4);
        e.dc   = dc;
        e.err  = experr;
        if (sel == 1) q1.push_back(e);
        else          q4.push_back(e);
        drive(sel, addr, rd, wr, mask, val);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = (sel == 1) ? bus1.ready_out : bus4.ready_out;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout dut%0d addr %h: got no ready expected ready within 40 cycles", sel, addr);
        end
        drive(sel, 64'h0, 1'b0, 1'b0, 8'h00, 64'h0);
        @(negedge clk);
    endtask

    // Monitor for the latency-1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (bus1.ready_out) begin
            if (q1.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dut1 spurious ready: got ready=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = q1.pop_front();
                check64("dut1 ready cycle", 64'(cyc), 64'(e.cyc));
                if (!e.dc) check64("dut1 read data", bus1.read_value_out, e.data);
                check64("dut1 error", {63'h0, err1}, {63'h0, e.err});
            end
        end else begin
            check64("dut1 idle data", bus1.read_value_out, 64'h0);
            check64("dut1 idle error", {63'h0, err1}, 64'h0);
        end
    end

    // Monitor for the latency-4 instance.
    always @(negedge clk) begin
        exp_t e;
        if (bus4.ready_out) begin
            if (q4.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dut4 spurious ready: got ready=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = q4.pop_front();
                check64("dut4 ready cycle", 64'(cyc), 64'(e.cyc));
                if (!e.dc) check64("dut4 read data", bus4.read_value_out, e.data);
                check64("dut4 error", {63'h0, err4}, {63'h0, e.err});
            end
        end else begin
            check64("dut4 idle data", bus4.read_value_out, 64'h0);
            check64("dut4 idle error", {63'h0, err4}, 64'h0);
        end
    end

    initial begin
        // reset with random inputs on both instances
        drive(1, {$urandom, $urandom}, 1'b1, 1'b1, 8'($urandom), {$urandom, $urandom});
        drive(4, {$urandom, $urandom}, 1'b1, 1'b1, 8'($urandom), {$urandom, $urandom});
        repeat (2) @(negedge clk);
        check64("reset dut1 ready", {63'h0, bus1.ready_out}, 64'h0);
        check64("reset dut1 data", bus1.read_value_out, 64'h0);
        check64("reset dut4 ready", {63'h0, bus4.ready_out}, 64'h0);
        drive(1, 64'h0, 1'b0, 1'b0, 8'h00, 64'h0);
        drive(4, 64'h0, 1'b0, 1'b0, 8'h00, 64'h0);
        rst1_n = 1'b1;
        rst4_n = 1'b1;
        @(negedge clk);

        // latency 1: full write, read back, partial mask, empty mask
        issue(1, 64'h10, 1'b0, 1'b1, 8'hFF, 64'h1122334455667788, 64'h0, 1'b1, 1'b0);
        issue(1, 64'h10, 1'b1, 1'b0, 8'h00, 64'h0, 64'h1122334455667788, 1'b0, 1'b0);
        issue(1, 64'h17, 1'b0, 1'b1, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 64'h1122334455667788, 1'b0, 1'b0);
        issue(1, 64'h10, 1'b1, 1'b0, 8'h00, 64'h0, 64'h11223344AAAAAAAA, 1'b0, 1'b0);
        issue(1, 64'h10, 1'b0, 1'b1, 8'h00, 64'hFFFFFFFFFFFFFFFF, 64'h11223344AAAAAAAA, 1'b0, 1'b0);
        issue(1, 64'h10, 1'b1, 1'b0, 8'h00, 64'h0, 64'h11223344AAAAAAAA, 1'b0, 1'b0);

        // simultaneous read and write returns the pre-write word
        issue(1, 64'h8, 1'b0, 1'b1, 8'hFF, 64'h5, 64'h0, 1'b1, 1'b0);
        issue(1, 64'h8, 1'b1, 1'b1, 8'hFF, 64'h9, 64'h5, 1'b0, 1'b0);
        issue(1, 64'h8, 1'b1, 1'b0, 8'h00, 64'h0, 64'h9, 1'b0, 1'b0);

        // one past the top word: error when range checking, else wraps to word 0
        issue(1, 64'h0, 1'b0, 1'b1, 8'hFF, 64'h77, 64'h0, 1'b1, 1'b0);
        issue(1, 64'h2000, 1'b0, 1'b1, 8'hFF, 64'h1234, ERR ? 64'h0 : 64'h77, 1'b0, ERR);
        issue(1, 64'h0, 1'b1, 1'b0, 8'h00, 64'h0, ERR ? 64'h77 : 64'h1234, 1'b0, 1'b0);

        // write presented during reset must not land
        drive(1, 64'h10, $urandom_range(0, 1) == 1, 1'b1, 8'hFF, {$urandom, $urandom});
        rst1_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check64("reset mid-run dut1 ready", {63'h0, bus1.ready_out}, 64'h0);
        end
        drive(1, 64'h0, 1'b0, 1'b0, 8'h00, 64'h0);
        rst1_n = 1'b1;
        @(negedge clk);
        issue(1, 64'h10, 1'b1, 1'b0, 8'h00, 64'h0, 64'h11223344AAAAAAAA, 1'b0, 1'b0);

        // latency 4 with nonzero base
        issue(4, 64'h1008, 1'b0, 1'b1, 8'hFF, 64'hDEAD, 64'h0, 1'b1, 1'b0);
        issue(4, 64'h1008, 1'b1, 1'b0, 8'h00, 64'h0, 64'hDEAD, 1'b0, 1'b0);
        issue(4, 64'h1008, 1'b0, 1'b1, 8'hC0, 64'hFFEE000000000000, 64'hDEAD, 1'b0, 1'b0);
        issue(4, 64'h1008, 1'b1, 1'b0, 8'h00, 64'h0, 64'hFFEE00000000DEAD, 1'b0, 1'b0);

        // reset while waiting: response abandoned, write kept
        drive(4, 64'h1010, 1'b0, 1'b1, 8'hFF, 64'hBEEF);
        @(negedge clk);
        drive(4, 64'h0, 1'b0, 1'b0, 8'h00, 64'h0);
        rst4_n = 1'b0;
        @(negedge clk);
        check64("reset in wait dut4 ready", {63'h0, bus4.ready_out}, 64'h0);
        rst4_n = 1'b1;
        @(negedge clk);
        issue(4, 64'h1010, 1'b1, 1'b0, 8'h00, 64'h0, 64'hBEEF, 1'b0, 1'b0);

        // one past the top word of the 16-word instance
        issue(4, 64'h1000, 1'b0, 1'b1, 8'hFF, 64'h55, 64'h0, 1'b1, 1'b0);
        issue(4, 64'h1080, 1'b0, 1'b1, 8'hFF, 64'h42, ERR ? 64'h0 : 64'h55, 1'b0, ERR);
        issue(4, 64'h1000, 1'b1, 1'b0, 8'h00, 64'h0, ERR ? 64'h55 : 64'h42, 1'b0, 1'b0);

        repeat (6) @(negedge clk);
        check64("dut1 responses outstanding", 64'(q1.size()), 64'h0);
        check64("dut4 responses outstanding", 64'(q4.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
        $fatal(1);
    end
endmodule
